// File: rtl/sb_arb2_if.sv
// Simple-bus (SB) port bundle: read address/data channels plus write/response channels.
interface sb_arb2_if;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic        wvalid;
   logic        wready;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic        bresp;

   modport master (
      output arvalid, araddr, rready, wvalid, waddr, wdata, wstrb, bready,
      input  arready, rvalid, rdata, wready, bvalid, bresp
   );

   modport slave (
      input  arvalid, araddr, rready, wvalid, waddr, wdata, wstrb, bready,
      output arready, rvalid, rdata, wready, bvalid, bresp
   );
endinterface

// File: rtl/sb_arb2.sv
// Two-master to one-slave SB arbiter; read and write paths arbitrate independently.
// Define SB_ARB_FIXED_PRIO_EN to replace round-robin with fixed m0-over-m1 priority.
module sb_arb2 #(
   parameter int OST_DEPTH = 4,
   parameter int OST_AW    = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   sb_arb2_if.slave  m0,
   sb_arb2_if.slave  m1,
   sb_arb2_if.master s
);

   // Index 0 is the read path (AR/R), index 1 the write path (W/B).
   logic [1:0] req_v   [2];
   logic [1:0] mst_rdy [2];
   logic [1:0] rsp_vm  [2];
   logic [1:0] rsp_rm  [2];
   logic [1:0] gnt;
   logic [1:0] slv_valid;
   logic [1:0] slv_ready;
   logic [1:0] rsp_valid;
   logic [1:0] rsp_ready_s;

   assign req_v[0]  = {m1.arvalid, m0.arvalid};
   assign req_v[1]  = {m1.wvalid, m0.wvalid};
   assign rsp_rm[0] = {m1.rready, m0.rready};
   assign rsp_rm[1] = {m1.bready, m0.bready};
   assign slv_ready = {s.wready, s.arready};
   assign rsp_valid = {s.bvalid, s.rvalid};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_path
         logic                 lock_reg;
         logic                 sel_reg;
         logic [OST_DEPTH-1:0] fifo_reg;
         logic [OST_AW:0]      wptr_reg;
         logic [OST_AW:0]      rptr_reg;
         logic                 pick;
         logic                 full;
         logic                 empty;
         logic                 head;
         logic                 push;
         logic                 pop;

         // Full when pointers differ only in the wrap bit.
         assign full  = (wptr_reg ^ rptr_reg) == {1'b1, {OST_AW{1'b0}}};
         assign empty = (wptr_reg == rptr_reg);

`ifdef SB_ARB_FIXED_PRIO_EN
         assign pick = ~req_v[gi][0];
`else
         logic rr_reg;
         assign pick = (req_v[gi] == 2'b11) ? rr_reg : req_v[gi][1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rr_reg <= 1'b0;
            end else if (push) begin
               rr_reg <= ~gnt[gi];
            end
         end
`endif

         assign gnt[gi]         = lock_reg ? sel_reg : pick;
         assign slv_valid[gi]   = req_v[gi][gnt[gi]] & ~full;
         assign mst_rdy[gi]     = {gnt[gi], ~gnt[gi]} & req_v[gi] & {2{slv_ready[gi] & ~full}};
         assign push            = slv_valid[gi] & slv_ready[gi];
         assign head            = fifo_reg[rptr_reg[OST_AW-1:0]];
         assign rsp_vm[gi]      = {head, ~head} & {2{rsp_valid[gi] & ~empty}};
         assign rsp_ready_s[gi] = ~empty & rsp_rm[gi][head];
         assign pop             = rsp_valid[gi] & rsp_ready_s[gi];

         // A stalled offer freezes the grant so the slave sees stable valid/address.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lock_reg <= 1'b0;
               sel_reg  <= 1'b0;
               fifo_reg <= '0;
               wptr_reg <= '0;
               rptr_reg <= '0;
            end else begin
               if (push) begin
                  fifo_reg[wptr_reg[OST_AW-1:0]] <= gnt[gi];
                  wptr_reg <= wptr_reg + 1'b1;
                  lock_reg <= 1'b0;
               end else if (slv_valid[gi]) begin
                  lock_reg <= 1'b1;
                  sel_reg  <= gnt[gi];
               end
               if (pop) begin
                  rptr_reg <= rptr_reg + 1'b1;
               end
            end
         end
      end
   endgenerate

   assign s.arvalid  = slv_valid[0];
   assign s.araddr   = gnt[0] ? m1.araddr : m0.araddr;
   assign s.wvalid   = slv_valid[1];
   assign s.waddr    = gnt[1] ? m1.waddr : m0.waddr;
   assign s.wdata    = gnt[1] ? m1.wdata : m0.wdata;
   assign s.wstrb    = gnt[1] ? m1.wstrb : m0.wstrb;
   assign s.rready   = rsp_ready_s[0];
   assign s.bready   = rsp_ready_s[1];

   assign m0.arready = mst_rdy[0][0];
   assign m1.arready = mst_rdy[0][1];
   assign m0.wready  = mst_rdy[1][0];
   assign m1.wready  = mst_rdy[1][1];
   assign m0.rvalid  = rsp_vm[0][0];
   assign m1.rvalid  = rsp_vm[0][1];
   assign m0.bvalid  = rsp_vm[1][0];
   assign m1.bvalid  = rsp_vm[1][1];
   assign m0.rdata   = s.rdata;
   assign m1.rdata   = s.rdata;
   assign m0.bresp   = s.bresp;
   assign m1.bresp   = s.bresp;

endmodule
